// File: rtl/nios2_dct_pkg.sv
// Shared constants and types for the OCI data/control trace packer.
package nios2_dct_pkg;

  localparam int DCT_ENTRY_W = 2;
  localparam int DCT_DEPTH   = 15;
  localparam int DCT_BUF_W   = 30;
  localparam int DCT_CNT_W   = 4;

  // Entry count of a full frame, sized to the count field.
  localparam logic [DCT_CNT_W-1:0] DCT_FULL_CNT = DCT_CNT_W'(DCT_DEPTH);

  // End-of-test sequencing.
  typedef enum logic [1:0] {
    RUN,
    ENDING,
    ENDED
  } end_state_t;

endpackage

// File: rtl/nios2_dct_out_reg.sv
// One-entry valid/ready holding register for finished trace frames.
module nios2_dct_out_reg
  import nios2_dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DCT_BUF_W-1:0] load_buffer,
  input  logic [DCT_CNT_W-1:0] load_count,
  input  logic                 out_ready,
  output logic [DCT_BUF_W-1:0] dct_buffer,
  output logic [DCT_CNT_W-1:0] dct_count,
  output logic                 out_valid,
  output logic                 out_free
);

  // A new frame may be loaded when the slot is empty or is being taken now.
  assign out_free = !out_valid || out_ready;

  // Load a frame, or retire the current one on handshake; data holds otherwise.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    if (reset) begin
      dct_buffer <= '0;
      dct_count  <= '0;
      out_valid  <= 1'b0;
    end else if (load) begin
      dct_buffer <= load_buffer;
      dct_count  <= load_count;
      out_valid  <= 1'b1;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/nios2_dct_packer.sv
// Packs 2-bit trace codes LSB-first into 30-bit frames and hands them to
// the trace consumer; also sequences the end-of-test flags.
module nios2_dct_packer
  import nios2_dct_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [DCT_ENTRY_W-1:0] in_data,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic                   end_req,
  output logic [DCT_BUF_W-1:0]   dct_buffer,
  output logic [DCT_CNT_W-1:0]   dct_count,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   test_ending,
  output logic                   test_has_ended
);

  logic [DCT_BUF_W-1:0] acc_buf, acc_buf_nxt;
  logic [DCT_CNT_W-1:0] acc_cnt, acc_cnt_nxt;
  logic [4:0]           wr_pos;
  logic                 accept, close_req, transfer, out_free;
  logic                 end_sticky, hold_pending;
  end_state_t           state, state_nxt;

  assign end_sticky = (state != RUN);

  // Accumulator next value, close decision and input backpressure.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    acc_buf_nxt  = acc_buf;
    wr_pos       = {acc_cnt, 1'b0};
    // A close that cannot move to the output register holds the accumulator;
    // this is judged without the current accept to avoid a ready/valid loop.
    hold_pending = !out_free &&
                   ((acc_cnt == DCT_FULL_CNT) || ((flush || end_sticky) && acc_cnt != '0));
    in_ready     = (state == RUN) && (acc_cnt != DCT_FULL_CNT) && !hold_pending;
    accept       = in_valid && in_ready;
    if (accept) begin
      acc_buf_nxt[wr_pos +: DCT_ENTRY_W] = in_data;
    end
    acc_cnt_nxt  = acc_cnt + DCT_CNT_W'(accept);
    // The entry accepted this cycle is part of the frame being closed.
    close_req    = (acc_cnt_nxt == DCT_FULL_CNT) ||
                   ((flush || end_sticky) && acc_cnt_nxt != '0);
    transfer     = close_req && out_free;
  end

  // Accumulator: clears on transfer, otherwise absorbs accepted entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_buf <= '0;
      acc_cnt <= '0;
    end else if (transfer) begin
      acc_buf <= '0;
      acc_cnt <= '0;
    end else if (accept) begin
      acc_buf <= acc_buf_nxt;
      acc_cnt <= acc_cnt_nxt;
    end
  end

  nios2_dct_out_reg u_out_reg (
    .clk         (clk),
    .reset       (reset),
    .load        (transfer),
    .load_buffer (acc_buf_nxt),
    .load_count  (acc_cnt_nxt),
    .out_ready   (out_ready),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count),
    .out_valid   (out_valid),
    .out_free    (out_free)
  );

  // End-sequence state register.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // End-sequence next state and flags; ENDED is left only by reset.
  always_comb begin
    state_nxt      = state;
    test_ending    = 1'b0;
    test_has_ended = 1'b0;
    unique case (state)
      RUN: begin
        if (end_req) state_nxt = ENDING;
      end
      ENDING: begin
        test_ending = 1'b1;
        if (acc_cnt == '0 && !out_valid) state_nxt = ENDED;
      end
      ENDED: begin
        test_ending    = 1'b1;
        test_has_ended = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: tb/tb_nios2_dct_packer.sv
// Scoreboard bench for nios2_dct_packer: directed stimulus pushes expected
// frames into a queue, a monitor compares each presented frame.
module tb_nios2_dct_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  in_data = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        end_req = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        test_ending;
  logic        test_has_ended;

  typedef struct {
    logic [29:0] buf_v;
    logic [3:0]  cnt;
  } frame_t;

  frame_t exp_q[$];
  int     checks = 0;
  int     failures = 0;

  nios2_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .flush          (flush),
    .end_req        (end_req),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [29:0] b, input logic [3:0] c);
    frame_t f;
    f.buf_v = b;
    f.cnt   = c;
    exp_q.push_back(f);
  endtask

  // Offer one code and wait (bounded) until it is accepted.
  task automatic push(input logic [1:0] code);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = code;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL push_timeout code=%0d never accepted", code);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle a frame is presented it must match the queue head.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame actual=0x%0h/%0d required=none", dct_buffer, dct_count);
      end else begin
        check("frame_buffer", 32'(dct_buffer), 32'(exp_q[0].buf_v));
        check("frame_count",  32'(dct_count),  32'(exp_q[0].cnt));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bit ended;

    // Reset state
    idle(2);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_dct_count", 32'(dct_count), 0);
    check("rst_dct_buffer", 32'(dct_buffer), 0);
    check("rst_test_ending", 32'(test_ending), 0);
    check("rst_test_has_ended", 32'(test_has_ended), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Full frame of 15 x 2'b01, one-cycle out_valid right after the 15th accept
    expect_frame(30'h15555555, 4'd15);
    for (int i = 0; i < 15; i++) push(2'b01);
    @(negedge clk);
    check("full_valid_first", 32'(out_valid), 1);
    @(negedge clk);
    check("full_valid_second", 32'(out_valid), 0);
    idle(2);

    // Partial flush 3,2,1 then a second flush with empty accumulator
    expect_frame(30'h0000001B, 4'd3);
    push(2'd3); push(2'd2); push(2'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle(3);

    // Flush in the same cycle as an accept
    expect_frame(30'h00000025, 4'd3);
    push(2'd1); push(2'd1);
    in_valid = 1'b1; in_data = 2'd2; flush = 1'b1;
    @(negedge clk);
    check("flush_accept_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    idle(3);

    // Backpressure: 31 entries of 2'b10 with out_ready low
    out_ready = 1'b0;
    expect_frame(30'h2AAAAAAA, 4'd15);
    expect_frame(30'h2AAAAAAA, 4'd15);
    expect_frame(30'h00000002, 4'd1);
    for (int i = 0; i < 30; i++) push(2'b10);
    in_valid = 1'b1; in_data = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 0);
      check("bp_held_valid", 32'(out_valid), 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(2'b10);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle(4);
    check("bp_queue_drained", 32'(exp_q.size()), 0);

    // Reset with 7 entries accumulated: nothing may come out afterwards
    for (int i = 0; i < 7; i++) push(2'd3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle(2);
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_dct_count", 32'(dct_count), 0);
    check("mid_rst_dct_buffer", 32'(dct_buffer), 0);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // End sequence: 5 entries pending, consumer stalled
    out_ready = 1'b0;
    expect_frame(30'h00000393, 4'd5);
    push(2'd3); push(2'd0); push(2'd1); push(2'd2); push(2'd3);
    end_req = 1'b1;
    @(posedge clk); #1;
    end_req = 1'b0;
    @(negedge clk);
    check("end_test_ending", 32'(test_ending), 1);
    check("end_in_ready", 32'(in_ready), 0);
    check("end_not_ended_yet", 32'(test_has_ended), 0);
    idle(3);
    @(negedge clk);
    check("end_stalled_not_ended", 32'(test_has_ended), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    ended = 1'b0;
    for (int i = 0; i < 50 && !ended; i++) begin
      @(negedge clk);
      if (test_has_ended) ended = 1'b1;
    end
    check("end_has_ended", 32'(ended), 1);
    check("end_ending_stays", 32'(test_ending), 1);
    check("end_queue_drained", 32'(exp_q.size()), 0);

    // Reset clears the end flags
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_test_ending", 32'(test_ending), 0);
    check("post_rst_has_ended", 32'(test_has_ended), 0);
    check("post_rst_in_ready", 32'(in_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
